// File: rtl/uart_stream_transmitter.sv
// UART transmitter draining a valid/ready word stream onto a single TX line.
// Frame: start bit, DATA_WIDTH bits LSB first, optional parity, 1 or 2 stop bits.
module uart_stream_transmitter #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 9600,
  parameter int DATA_WIDTH      = 8,
  parameter int PARITY_MODE     = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  tx,
  output logic                  busy
);

  localparam int CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W          = (CLOCKS_PER_BIT < 2) ? 1 : $clog2(CLOCKS_PER_BIT);
  localparam int IDX_W          = 4;
  localparam bit HAS_PARITY     = (PARITY_MODE == 1) || (PARITY_MODE == 2);
  localparam int STOP_COUNT     = (STOP_BITS == 2) ? 2 : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_COUNT - 1);

  if (CLOCKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_stream_transmitter: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
  end

  if ((DATA_WIDTH < 5) || (DATA_WIDTH > 9)) begin : g_bad_width
    $error("uart_stream_transmitter: DATA_WIDTH must lie in 5..9");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Odd parity is the inverse of the even-parity XOR.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data);
    parity_bit = (^data) ^ (PARITY_MODE == 2);
  endfunction

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [IDX_W-1:0]        idx_r, idx_s;
  logic [DATA_WIDTH-1:0]   shift_r, shift_s;
  logic                    parity_r, parity_s;
  logic                    tx_r, tx_s;
  logic                    busy_r, busy_s;
  logic                    bit_end_s;

  assign in_ready = (state_r == IDLE);
  assign tx       = tx_r;
  assign busy     = busy_r;

  // Next-state, bit timing and next registered line level
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    shift_s   = shift_r;
    parity_s  = parity_r;
    bit_end_s = (cnt_r == CNT_LAST);

    if (state_r == IDLE) begin
      cnt_s = '0;
    end else if (bit_end_s) begin
      cnt_s = '0;
    end else begin
      cnt_s = cnt_r + CNT_W'(1);
    end

    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s  = START;
          shift_s  = in_data;
          parity_s = parity_bit(in_data);
          idx_s    = '0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s = DATA;
          idx_s   = '0;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (!bit_end_s) begin
          state_s = DATA;
        end else if (idx_r == DATA_LAST) begin
          idx_s   = '0;
          state_s = HAS_PARITY ? PARITY : STOP;
        end else begin
          idx_s   = idx_r + IDX_W'(1);
          shift_s = shift_r >> 1;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          state_s = STOP;
          idx_s   = '0;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        if (!bit_end_s) begin
          state_s = STOP;
        end else if (idx_r == STOP_LAST) begin
          idx_s   = '0;
          state_s = IDLE;
        end else begin
          idx_s = idx_r + IDX_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = '0;
      end
    endcase

    // The line level is decoded from the next state so tx comes straight off a flop.
    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
      PARITY:  tx_s = parity_s;
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase

    busy_s = (state_s != IDLE);
  end

  // State, datapath and registered line outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      idx_r    <= '0;
      shift_r  <= '0;
      parity_r <= 1'b0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      shift_r  <= shift_s;
      parity_r <= parity_s;
      tx_r     <= tx_s;
      busy_r   <= busy_s;
    end
  end

endmodule

// File: tb/tb_uart_stream_transmitter.sv
// Scoreboard bench for uart_stream_transmitter: four frame formats at 10 clocks per bit.
module tb_uart_stream_transmitter;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic       clock;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic [1:0] sel;
  logic [3:0] tx_v, in_ready_v, busy_v;
  logic       tx_sel, in_ready_sel, busy_sel;
  bit         mon_en, mon_busy;
  int         cyc;
  int         compared, mismatched;
  exp_t       exp_q[$];
  int         start_cyc_q[$];

  assign tx_sel       = tx_v[sel];
  assign in_ready_sel = in_ready_v[sel];
  assign busy_sel     = busy_v[sel];

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2
  uart_stream_transmitter #(.CLOCK_FREQUENCY(1000000), .BAUD_RATE(100000), .DATA_WIDTH(8),
    .PARITY_MODE(0), .STOP_BITS(1)) dut_n1 (.clock(clock), .reset(reset), .in_data(in_data),
    .in_valid(in_valid && (sel == 2'd0)), .in_ready(in_ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]));
  uart_stream_transmitter #(.CLOCK_FREQUENCY(1000000), .BAUD_RATE(100000), .DATA_WIDTH(8),
    .PARITY_MODE(1), .STOP_BITS(1)) dut_e1 (.clock(clock), .reset(reset), .in_data(in_data),
    .in_valid(in_valid && (sel == 2'd1)), .in_ready(in_ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]));
  uart_stream_transmitter #(.CLOCK_FREQUENCY(1000000), .BAUD_RATE(100000), .DATA_WIDTH(8),
    .PARITY_MODE(2), .STOP_BITS(1)) dut_o1 (.clock(clock), .reset(reset), .in_data(in_data),
    .in_valid(in_valid && (sel == 2'd2)), .in_ready(in_ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]));
  uart_stream_transmitter #(.CLOCK_FREQUENCY(1000000), .BAUD_RATE(100000), .DATA_WIDTH(8),
    .PARITY_MODE(0), .STOP_BITS(2)) dut_n2 (.clock(clock), .reset(reset), .in_data(in_data),
    .in_valid(in_valid && (sel == 2'd3)), .in_ready(in_ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]));

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Called on the first low sample of a frame; walks every cycle of every bit slot.
  task automatic check_frame();
    exp_t       e;
    logic [7:0] got;
    logic       lvl;
    bit         bad_lvl, bad_hs;
    int         pm, sb, nslots;
    mon_busy = 1'b1;
    start_cyc_q.push_back(cyc);
    if (exp_q.size() == 0) begin
      check(1'b0, "unexpected_frame", 1, 0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    pm = (sel == 2'd1) ? 1 : ((sel == 2'd2) ? 2 : 0);
    sb = (sel == 2'd3) ? 2 : 1;
    nslots = 1 + 8 + ((pm != 0) ? 1 : 0) + sb;
    got = '0;
    bad_lvl = 1'b0;
    bad_hs = 1'b0;
    for (int s = 0; s < nslots; s++) begin
      if (s == 0) lvl = 1'b0;
      else if (s <= 8) lvl = e.data[s-1];
      else if ((s == 9) && (pm != 0)) lvl = e.par;
      else lvl = 1'b1;
      for (int c = 0; c < 10; c++) begin
        if ((s != 0) || (c != 0)) @(negedge clock);
        if (tx_sel !== lvl) bad_lvl = 1'b1;
        if ((in_ready_sel !== 1'b0) || (busy_sel !== 1'b1)) bad_hs = 1'b1;
        if ((c == 5) && (s >= 1) && (s <= 8)) got[s-1] = tx_sel;
      end
    end
    @(negedge clock);
    check(got == e.data, "decoded_byte", got, e.data);
    check(!bad_lvl, "bit_levels", bad_lvl, 0);
    check(!bad_hs, "ready_busy_in_frame", bad_hs, 0);
    check({tx_sel, in_ready_sel, busy_sel} === 3'b110, "line_after_frame",
          {tx_sel, in_ready_sel, busy_sel}, 3'b110);
    mon_busy = 1'b0;
  endtask

  // Monitor: detects start-bit falling edges on the selected DUT
  initial begin : monitor
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (mon_en && !reset && prev && (tx_sel === 1'b0)) begin
        check_frame();
        prev = 1'b1;
      end else begin
        prev = tx_sel;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic p, input bit expect_it);
    int n;
    n = 0;
    while ((in_ready_sel !== 1'b1) && (n < 500)) begin
      @(negedge clock);
      n++;
    end
    if (n >= 500) check(1'b0, "ready_timeout", n, 500);
    in_data  = d;
    in_valid = 1'b1;
    if (expect_it) exp_q.push_back({d, p});
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (((exp_q.size() != 0) || mon_busy) && (n < 3000)) begin
      @(negedge clock);
      n++;
    end
    if (n >= 3000) check(1'b0, "drain_timeout", n, 3000);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n0, n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    sel      = 2'd0;
    mon_en   = 1'b1;
    repeat (3) @(negedge clock);
    check({tx_v, in_ready_v, busy_v} === 12'hFF0, "reset_state", {tx_v, in_ready_v, busy_v}, 12'hFF0);
    reset = 1'b0;
    @(negedge clock);
    check({tx_v, in_ready_v, busy_v} === 12'hFF0, "after_release", {tx_v, in_ready_v, busy_v}, 12'hFF0);

    // 8N1 alternating pattern, then 8E1 and 8O1 with 0x07 (three ones)
    sel = 2'd0; send(8'h55, 1'b0, 1'b1); drain();
    sel = 2'd1; send(8'h07, 1'b1, 1'b1); drain();
    sel = 2'd2; send(8'h07, 1'b0, 1'b1); drain();

    // Back-to-back with in_valid held high
    sel = 2'd0;
    n0 = start_cyc_q.size();
    exp_q.push_back({8'hA5, 1'b0});
    exp_q.push_back({8'h3C, 1'b0});
    in_data  = 8'hA5;
    in_valid = 1'b1;
    @(negedge clock);
    in_data = 8'h3C;
    n = 0;
    while ((in_ready_sel !== 1'b1) && (n < 200)) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check(1'b0, "gap_timeout", n, 200);
    @(negedge clock);
    in_valid = 1'b0;
    drain();
    repeat (150) @(negedge clock);
    check(start_cyc_q.size() == n0 + 2, "frames_accepted", start_cyc_q.size() - n0, 2);
    if (start_cyc_q.size() >= n0 + 2) begin
      check(start_cyc_q[n0+1] - start_cyc_q[n0] == 101, "start_spacing",
            start_cyc_q[n0+1] - start_cyc_q[n0], 101);
    end else begin
      check(1'b0, "start_spacing", 0, 101);
    end

    // Two stop bits
    sel = 2'd3; send(8'h81, 1'b0, 1'b1); drain();

    // in_data toggles while in_valid stays high inside the frame
    sel = 2'd0;
    send(8'h3B, 1'b0, 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 90; i++) begin
      in_data = in_data ^ 8'hFF;
      @(negedge clock);
    end
    in_valid = 1'b0;
    drain();

    // Reset in cycle 35 of a frame (data bit 2 of 0x5A is 0)
    mon_en = 1'b0;
    send(8'h5A, 1'b0, 1'b0);
    repeat (35) @(negedge clock);
    check({tx_sel, busy_sel} === 2'b01, "pre_reset_line", {tx_sel, busy_sel}, 2'b01);
    reset = 1'b1;
    #1;
    check({tx_sel, busy_sel, in_ready_sel} === 3'b101, "mid_frame_reset",
          {tx_sel, busy_sel, in_ready_sel}, 3'b101);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check({tx_sel, busy_sel, in_ready_sel} === 3'b101, "post_reset_idle",
          {tx_sel, busy_sel, in_ready_sel}, 3'b101);
    mon_en = 1'b1;
    send(8'hC3, 1'b0, 1'b1);
    drain();
    repeat (20) @(negedge clock);
    check(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
